// File: rtl/perf_monitor.sv
// Multi-channel performance monitor: a cycle counter plus event counters, a run/done FSM with
// final-PC and hang detection, and a registered readout port for the hex displays.
module perf_monitor #(
  parameter int unsigned          NUM_CHANNELS = 4,
  parameter int unsigned          COUNT_WIDTH  = 32,
  parameter int unsigned          PC_WIDTH     = 10,
  parameter logic [PC_WIDTH-1:0]  FINAL_PC     = {PC_WIDTH{1'b1}},
  parameter int unsigned          HANG_LIMIT   = 1024,
  parameter int unsigned          SEL_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  parameter int unsigned          IDX_WIDTH    = (COUNT_WIDTH > 4) ? $clog2(COUNT_WIDTH / 4) : 1
) (
  input  logic                    CLK_50,
  input  logic                    resetN,
  input  logic                    start,
  input  logic                    clear,
  input  logic [PC_WIDTH-1:0]     pc,
  // `event` is a reserved word, hence the plural name.
  input  logic [NUM_CHANNELS-1:0] events,
  input  logic [SEL_WIDTH-1:0]    rd_sel,
  input  logic [IDX_WIDTH-1:0]    digit_idx,
  output logic [COUNT_WIDTH-1:0]  rd_value,
  output logic                    rd_ovf,
  output logic [3:0]              digit,
  output logic                    running,
  output logic                    finished,
  output logic                    hang
);

  localparam int unsigned              NumNibbles = COUNT_WIDTH / 4;
  localparam int unsigned              HrunWidth  = (HANG_LIMIT > 2) ? $clog2(HANG_LIMIT) : 1;
  localparam logic [HrunWidth-1:0]     HrunTarget = HrunWidth'(HANG_LIMIT - 1);
  localparam logic [HrunWidth-1:0]     HrunOne    = HrunWidth'(1);
  localparam logic [COUNT_WIDTH-1:0]   CntOne     = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e                  r_state;
  state_e                  w_state_d;
  logic                    r_hang;
  logic                    w_hang_d;
  logic [HrunWidth-1:0]    r_hrun;
  logic [HrunWidth-1:0]    w_hrun_d;
  logic [PC_WIDTH-1:0]     r_last_pc;
  logic [COUNT_WIDTH-1:0]  r_cnt [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] r_ovf;
  logic [NUM_CHANNELS-1:0] w_inc;
  logic [COUNT_WIDTH-1:0]  r_rd_value;
  logic [COUNT_WIDTH-1:0]  w_rd_value;
  logic                    r_rd_ovf;
  logic                    w_rd_ovf;
  logic [3:0]              w_digit;
  logic                    w_run;
  logic                    w_same_pc;
  logic                    w_at_final;
  logic                    w_hang_hit;

  assign w_run      = (r_state == StRun);
  assign w_same_pc  = (pc == r_last_pc);
  assign w_at_final = (pc == FINAL_PC);
  assign w_hang_hit = (HANG_LIMIT != 0) && w_same_pc && (r_hrun == HrunTarget);

  always_comb begin
    w_state_d = r_state;
    w_hang_d  = r_hang;
    w_hrun_d  = '0;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_d = StRun;
      end
      StRun: begin
        if (w_same_pc) w_hrun_d = (&r_hrun) ? r_hrun : r_hrun + HrunOne;
        // Final PC wins over hang so a self-loop at FINAL_PC ends as a normal finish.
        if (w_at_final) begin
          w_state_d = StDone;
          w_hang_d  = 1'b0;
        end else if (w_hang_hit) begin
          w_state_d = StDone;
          w_hang_d  = 1'b1;
        end
      end
      StDone: begin
        w_state_d = StDone;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    if (clear) begin
      w_state_d = StIdle;
      w_hang_d  = 1'b0;
      w_hrun_d  = '0;
    end
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      r_state    <= StIdle;
      r_hang     <= 1'b0;
      r_hrun     <= '0;
      r_last_pc  <= '0;
      r_rd_value <= '0;
      r_rd_ovf   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_hang     <= w_hang_d;
      r_hrun     <= w_hrun_d;
      r_last_pc  <= pc;
      r_rd_value <= w_rd_value;
      r_rd_ovf   <= w_rd_ovf;
    end
  end

  // Channel 0 counts every RUN cycle; events[0] is deliberately ignored.
  always_comb begin
    w_inc = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_inc[i] = w_run & ((i == 0) | events[i]);
    end
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_CHANNELS; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CHANNELS; i++) r_cnt[i] <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (w_inc[i]) begin
          if (&r_cnt[i]) r_ovf[i]  <= 1'b1;
          else           r_cnt[i] <= r_cnt[i] + CntOne;
        end
      end
    end
  end

  always_comb begin
    w_rd_value = '0;
    w_rd_ovf   = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_sel == SEL_WIDTH'(i)) begin
        w_rd_value = r_cnt[i];
        w_rd_ovf   = r_ovf[i];
      end
    end
  end

  always_comb begin
    w_digit = 4'h0;
    for (int k = 0; k < NumNibbles; k++) begin
      if (digit_idx == IDX_WIDTH'(k)) w_digit = r_rd_value[4*k +: 4];
    end
  end

  assign rd_value = r_rd_value;
  assign rd_ovf   = r_rd_ovf;
  assign digit    = w_digit;
  assign running  = (r_state == StRun);
  assign finished = (r_state == StDone);
  assign hang     = r_hang;

endmodule
